// File: rtl/fetch_timing.sv
// Instruction-fetch and machine-cycle timing stage for a 4-bit CPU.
// Runs the 8-phase A1..X3 cycle, owns the PC and latches opcode bytes.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset (overrides hold and jumpEn)
//   hold       freezes phase counter, PC and all captures while high
//   romData    ROM byte at romAddr, valid by phase M1
//   jumpEn     PC load request, sampled only at X3
//   jumpAddr   PC value loaded when jumpEn is accepted
//   romAddr    current PC, drives the ROM
//   cycle      machine phase 0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3
//   sync       high during X3
//   opr/opa    instruction upper / lower nibble
//   operand2   second byte of a two-word instruction
//   secondWord high for the whole frame that fetches a second byte
module fetch_timing #(
    parameter int unsigned         PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic [7:0]          romData,
    input  logic                jumpEn,
    input  logic [PC_WIDTH-1:0] jumpAddr,
    output logic [PC_WIDTH-1:0] romAddr,
    output logic [2:0]          cycle,
    output logic                sync,
    output logic [3:0]          opr,
    output logic [3:0]          opa,
    output logic [7:0]          operand2,
    output logic                secondWord
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    localparam logic [PC_WIDTH-1:0] PC_ONE =
        {{(PC_WIDTH-1){1'b0}}, 1'b1};

    phase_e              phase_q, phase_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]          opr_q, opr_d;
    logic [3:0]          opa_q, opa_d;
    logic [7:0]          op2_q, op2_d;
    logic                sw_q, sw_d;
    logic                two_word;
    logic                jump_ok;

    // Opcodes that carry a second ROM byte: JCN, FIM (even pair),
    // JUN, JMS, ISZ. Decoded from the latched nibbles, which are
    // stable by X3.
    always_comb begin
        two_word = 1'b0;
        unique case (opr_q)
            4'h1,
            4'h4,
            4'h5,
            4'h7:    two_word = 1'b1;
            4'h2:    two_word = ~opa_q[0];
            default: two_word = 1'b0;
        endcase
    end

    // A jump requested during the first frame of a two-word opcode is
    // dropped so the second byte is always fetched from PC+1.
    assign jump_ok = jumpEn & (sw_q | ~two_word);

    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        opr_d   = opr_q;
        opa_d   = opa_q;
        op2_d   = op2_q;
        sw_d    = sw_q;
        if (!hold) begin
            phase_d = phase_e'(phase_q + 3'd1);
            unique case (phase_q)
                PH_M1: begin
                    if (sw_q) op2_d[7:4] = romData[7:4];
                    else      opr_d      = romData[7:4];
                end
                PH_M2: begin
                    if (sw_q) op2_d[3:0] = romData[3:0];
                    else      opa_d      = romData[3:0];
                end
                PH_X3: begin
                    if (jump_ok) pc_d = jumpAddr;
                    else         pc_d = pc_q + PC_ONE;
                    // Set after a two-word first frame, cleared after
                    // the second frame.
                    sw_d = ~sw_q & two_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_A1;
            pc_q    <= RESET_PC;
            opr_q   <= 4'h0;
            opa_q   <= 4'h0;
            op2_q   <= 8'h00;
            sw_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            opr_q   <= opr_d;
            opa_q   <= opa_d;
            op2_q   <= op2_d;
            sw_q    <= sw_d;
        end
    end

    assign romAddr    = pc_q;
    assign cycle      = phase_q;
    assign sync       = (phase_q == PH_X3);
    assign opr        = opr_q;
    assign opa        = opa_q;
    assign operand2   = op2_q;
    assign secondWord = sw_q;

endmodule

// File: tb/tb_fetch_timing.sv
// Self-checking bench for fetch_timing.
// Directed scenarios plus randomized run against a behavioural model.
module tb_fetch_timing;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [7:0]  romData;
    logic        jumpEn;
    logic [11:0] jumpAddr;
    logic [11:0] romAddr;
    logic [2:0]  cycle;
    logic        sync;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [7:0]  operand2;
    logic        secondWord;

    logic [7:0]  rom [0:4095];

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_cycle;
    logic [11:0] m_pc;
    logic [3:0]  m_opr;
    logic [3:0]  m_opa;
    logic [7:0]  m_op2;
    logic        m_sw;

    always #5 clk = ~clk;

    assign romData = rom[romAddr];

    fetch_timing #(
        .PC_WIDTH (12),
        .RESET_PC (12'h000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .romData    (romData),
        .jumpEn     (jumpEn),
        .jumpAddr   (jumpAddr),
        .romAddr    (romAddr),
        .cycle      (cycle),
        .sync       (sync),
        .opr        (opr),
        .opa        (opa),
        .operand2   (operand2),
        .secondWord (secondWord)
    );

    function automatic bit is_two(input logic [3:0] o, input logic [3:0] a);
        return (o == 4'h1) || (o == 4'h4) || (o == 4'h5) ||
               (o == 4'h7) || (o == 4'h2 && a[0] == 1'b0);
    endfunction

    // One machine phase of the instruction-fetch rules.
    task automatic model_step();
        logic [7:0] b;
        bit         two;
        b = rom[m_pc];
        if (rst) begin
            m_cycle = 0;
            m_pc    = 12'h000;
            m_opr   = 4'h0;
            m_opa   = 4'h0;
            m_op2   = 8'h00;
            m_sw    = 1'b0;
        end else if (!hold) begin
            if (m_cycle == 3) begin
                if (m_sw) m_op2[7:4] = b[7:4];
                else      m_opr      = b[7:4];
            end
            if (m_cycle == 4) begin
                if (m_sw) m_op2[3:0] = b[3:0];
                else      m_opa      = b[3:0];
            end
            if (m_cycle == 7) begin
                two = !m_sw && is_two(m_opr, m_opa);
                if (jumpEn && !two) m_pc = jumpAddr;
                else                m_pc = m_pc + 12'd1;
                m_sw = two;
            end
            m_cycle = (m_cycle + 1) % 8;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        hold     = 1'b1;
        jumpEn   = 1'b1;
        jumpAddr = 12'h5A5;
        tick();
        tick();
        rst    = 1'b0;
        hold   = 1'b0;
        jumpEn = 1'b0;
        checks++;
        if (cycle !== 3'd0) begin
            errors++;
            $display("FAIL reset_cycle: got %0d want 0", cycle);
        end
        checks++;
        if (romAddr !== 12'h000) begin
            errors++;
            $display("FAIL reset_pc: got %h want 000", romAddr);
        end
        checks++;
        if (opr !== 4'h0 || opa !== 4'h0) begin
            errors++;
            $display("FAIL reset_op: got %h%h want 00", opr, opa);
        end
        checks++;
        if (operand2 !== 8'h00 || secondWord !== 1'b0 || sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_misc: op2=%h sw=%b sync=%b want 00 0 0",
                     operand2, secondWord, sync);
        end
    endtask

    task automatic test_single_word();
        clear_rom();
        rom[0] = 8'hD5;
        rom[1] = 8'h00;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cycle !== 3'(k) || sync !== (k == 7)) begin
                errors++;
                $display("FAIL sw_phase: cycle=%0d sync=%b want %0d %b",
                         cycle, sync, k, (k == 7));
            end
            checks++;
            if (opr !== ((k >= 4) ? 4'hD : 4'h0) ||
                opa !== ((k >= 5) ? 4'h5 : 4'h0)) begin
                errors++;
                $display("FAIL sw_capture: k=%0d got %h%h", k, opr, opa);
            end
            checks++;
            if (romAddr !== 12'h000 || secondWord !== 1'b0) begin
                errors++;
                $display("FAIL sw_addr: k=%0d pc=%h sw=%b want 000 0",
                         k, romAddr, secondWord);
            end
            tick();
        end
        checks++;
        if (romAddr !== 12'h001 || cycle !== 3'd0 || secondWord !== 1'b0) begin
            errors++;
            $display("FAIL sw_next: pc=%h cycle=%0d sw=%b want 001 0 0",
                     romAddr, cycle, secondWord);
        end
    endtask

    task automatic test_jun();
        clear_rom();
        rom[0] = 8'h40;
        rom[1] = 8'h23;
        do_reset();
        jumpEn   = 1'b1;
        jumpAddr = 12'h023;
        ticks(8);
        checks++;
        if (romAddr !== 12'h001 || secondWord !== 1'b1) begin
            errors++;
            $display("FAIL jun_frame1: pc=%h sw=%b want 001 1",
                     romAddr, secondWord);
        end
        ticks(5);
        checks++;
        if (opr !== 4'h4 || opa !== 4'h0 || operand2 !== 8'h23 ||
            secondWord !== 1'b1) begin
            errors++;
            $display("FAIL jun_frame2: op=%h%h op2=%h sw=%b want 40 23 1",
                     opr, opa, operand2, secondWord);
        end
        ticks(3);
        checks++;
        if (romAddr !== 12'h023 || secondWord !== 1'b0) begin
            errors++;
            $display("FAIL jun_target: pc=%h sw=%b want 023 0",
                     romAddr, secondWord);
        end
        jumpEn = 1'b0;
    endtask

    task automatic test_fim();
        clear_rom();
        rom[0] = 8'h22;
        rom[1] = 8'hAB;
        do_reset();
        ticks(8);
        checks++;
        if (secondWord !== 1'b1 || romAddr !== 12'h001) begin
            errors++;
            $display("FAIL fim_sw: sw=%b pc=%h want 1 001",
                     secondWord, romAddr);
        end
        ticks(5);
        checks++;
        if (operand2 !== 8'hAB || opr !== 4'h2 || opa !== 4'h2) begin
            errors++;
            $display("FAIL fim_op2: op2=%h op=%h%h want AB 22",
                     operand2, opr, opa);
        end
        ticks(3);
        checks++;
        if (secondWord !== 1'b0 || romAddr !== 12'h002) begin
            errors++;
            $display("FAIL fim_end: sw=%b pc=%h want 0 002",
                     secondWord, romAddr);
        end
        rom[0] = 8'h23;
        do_reset();
        ticks(8);
        checks++;
        if (secondWord !== 1'b0 || romAddr !== 12'h001) begin
            errors++;
            $display("FAIL src_sw: sw=%b pc=%h want 0 001",
                     secondWord, romAddr);
        end
        ticks(5);
        checks++;
        if (opr !== 4'hA || opa !== 4'hB || operand2 !== 8'h00) begin
            errors++;
            $display("FAIL src_next: op=%h%h op2=%h want AB 00",
                     opr, opa, operand2);
        end
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0] = 8'h31;
        do_reset();
        jumpEn   = 1'b1;
        jumpAddr = 12'hFFF;
        ticks(8);
        jumpEn = 1'b0;
        checks++;
        if (romAddr !== 12'hFFF) begin
            errors++;
            $display("FAIL jin_load: pc=%h want FFF", romAddr);
        end
        ticks(8);
        checks++;
        if (romAddr !== 12'h000) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h want 000", romAddr);
        end
    endtask

    task automatic test_hold();
        clear_rom();
        rom[0] = 8'h9C;
        do_reset();
        ticks(3);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cycle !== 3'd3 || romAddr !== 12'h000 ||
                opr !== 4'h0 || opa !== 4'h0) begin
                errors++;
                $display("FAIL hold_frozen: cycle=%0d pc=%h op=%h%h",
                         cycle, romAddr, opr, opa);
            end
        end
        hold = 1'b0;
        tick();
        checks++;
        if (cycle !== 3'd4 || opr !== 4'h9 || opa !== 4'h0) begin
            errors++;
            $display("FAIL hold_m1: cycle=%0d op=%h%h want 4 90",
                     cycle, opr, opa);
        end
        tick();
        checks++;
        if (cycle !== 3'd5 || opr !== 4'h9 || opa !== 4'hC) begin
            errors++;
            $display("FAIL hold_m2: cycle=%0d op=%h%h want 5 9C",
                     cycle, opr, opa);
        end
    endtask

    task automatic test_reset_mid();
        clear_rom();
        rom[0] = 8'h51;
        rom[1] = 8'h77;
        do_reset();
        ticks(12);
        checks++;
        if (secondWord !== 1'b1 || operand2[7:4] !== 4'h7) begin
            errors++;
            $display("FAIL jms_setup: sw=%b op2=%h want 1 7x",
                     secondWord, operand2);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (cycle !== 3'd0 || romAddr !== 12'h000 || opr !== 4'h0 ||
            opa !== 4'h0 || operand2 !== 8'h00 || secondWord !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: c=%0d pc=%h op=%h%h op2=%h sw=%b",
                     cycle, romAddr, opr, opa, operand2, secondWord);
        end
        ticks(10);
        rst  = 1'b1;
        hold = 1'b1;
        tick();
        rst  = 1'b0;
        checks++;
        if (cycle !== 3'd0 || romAddr !== 12'h000 || opr !== 4'h0 ||
            opa !== 4'h0 || secondWord !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold: c=%0d pc=%h op=%h%h sw=%b",
                     cycle, romAddr, opr, opa, secondWord);
        end
        tick();
        checks++;
        if (cycle !== 3'd0) begin
            errors++;
            $display("FAIL rst_hold_frz: cycle=%0d want 0", cycle);
        end
        hold = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            jumpEn   = ($urandom_range(0, 3) == 0);
            jumpAddr = 12'($urandom);
            tick();
            checks++;
            if (cycle !== 3'(m_cycle) || sync !== (m_cycle == 7) ||
                romAddr !== m_pc) begin
                errors++;
                $display("FAIL rnd_timing: n=%0d c=%0d pc=%h want %0d %h",
                         n, cycle, romAddr, m_cycle, m_pc);
            end
            checks++;
            if (opr !== m_opr || opa !== m_opa || operand2 !== m_op2 ||
                secondWord !== m_sw) begin
                errors++;
                $display("FAIL rnd_data: n=%0d got %h%h %h %b want %h%h %h %b",
                         n, opr, opa, operand2, secondWord,
                         m_opr, m_opa, m_op2, m_sw);
            end
        end
        rst    = 1'b0;
        hold   = 1'b0;
        jumpEn = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        hold     = 1'b0;
        jumpEn   = 1'b0;
        jumpAddr = 12'h000;
        m_cycle  = 0;
        m_pc     = 12'h000;
        m_opr    = 4'h0;
        m_opa    = 4'h0;
        m_op2    = 8'h00;
        m_sw     = 1'b0;
        clear_rom();
        #2;
        test_reset();
        test_single_word();
        test_jun();
        test_fim();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
